// File: rtl/lbus_drp_slave.sv
// Local-bus responder: serves CPU strobes from ebi_interface, either from a small
// local register set (addr[11]=0) or by bridging to a 7-bit DRP port with timeout.
module lbus_drp_slave #(
  parameter int                            P_BUS_ADDR_WIDTH = 12,
  parameter int                            P_BUS_DATA_WIDTH = 16,
  parameter int                            P_DRP_TIMEOUT    = 64,
  parameter logic [P_BUS_DATA_WIDTH-1:0]   P_BLOCK_ID       = 16'h5844
) (
  input  logic                          clk_cfg,
  input  logic                          rst_cfg,
  input  logic [P_BUS_ADDR_WIDTH-1:0]   lbus_addr,
  input  logic [P_BUS_DATA_WIDTH-1:0]   lbus_wdata,
  output logic [P_BUS_DATA_WIDTH-1:0]   lbus_rdata,
  input  logic                          lbus_oe_n,
  input  logic                          lbus_we_n,
  output logic                          lbus_wait_n,
  output logic                          drp_den,
  output logic                          drp_dwe,
  output logic [6:0]                    drp_daddr,
  output logic [P_BUS_DATA_WIDTH-1:0]   drp_di,
  input  logic [P_BUS_DATA_WIDTH-1:0]   drp_do,
  input  logic                          drp_drdy
);

  localparam int L_CW = (P_DRP_TIMEOUT > 2) ? $clog2(P_DRP_TIMEOUT) : 1;
  localparam logic [L_CW-1:0]             L_CNT_MAX = L_CW'(P_DRP_TIMEOUT - 1);
  localparam logic [P_BUS_DATA_WIDTH-1:0] L_DEAD    = P_BUS_DATA_WIDTH'(16'hDEAD);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_LOCAL    = 3'd1;
  localparam logic [2:0] S_DRP_REQ  = 3'd2;
  localparam logic [2:0] S_DRP_WAIT = 3'd3;
  localparam logic [2:0] S_DONE     = 3'd4;

  logic [2:0]                  r_state;
  logic                        r_strobe;
  logic                        r_strobe_d;
  logic                        r_rd;
  logic                        r_wr;
  logic                        r_is_wr;
  logic [10:0]                 r_addr;
  logic [P_BUS_DATA_WIDTH-1:0] r_wdata;
  logic [L_CW-1:0]             r_cnt;
  logic [P_BUS_DATA_WIDTH-1:0] r_scratch;
  logic [P_BUS_DATA_WIDTH-1:0] r_err_cnt;
  logic [P_BUS_DATA_WIDTH-1:0] r_rdata;
  logic                        r_wait_n;
  logic                        r_den;
  logic                        r_dwe;
  logic [6:0]                  r_daddr;
  logic [P_BUS_DATA_WIDTH-1:0] r_di;
  logic                        w_new_access;

  assign w_new_access = r_strobe & ~r_strobe_d;

  // NOTE: every register uses non-blocking assignment so all of them sample pre-edge values.
  always_ff @(posedge clk_cfg) begin
    if (rst_cfg) begin
      r_state    <= S_IDLE;
      // Strobe history resets to "asserted" so a strobe held low across reset
      // is not mistaken for a fresh access and never re-issues drp_den.
      r_strobe   <= 1'b1;
      r_strobe_d <= 1'b1;
      r_rd       <= 1'b0;
      r_wr       <= 1'b0;
      r_is_wr    <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_cnt      <= '0;
      r_scratch  <= '0;
      r_err_cnt  <= '0;
      r_rdata    <= '0;
      r_wait_n   <= 1'b1;
      r_den      <= 1'b0;
      r_dwe      <= 1'b0;
      r_daddr    <= '0;
      r_di       <= '0;
    end else begin
      r_strobe   <= ~lbus_oe_n | ~lbus_we_n;
      r_strobe_d <= r_strobe;
      r_rd       <= ~lbus_oe_n;
      r_wr       <= ~lbus_we_n;
      r_den      <= 1'b0;
      r_dwe      <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_new_access) begin
            r_wait_n <= 1'b0;
            r_rdata  <= '0;
            r_addr   <= lbus_addr[10:0];
            r_wdata  <= lbus_wdata;
            r_is_wr  <= r_wr;
            if (r_rd && r_wr) begin
              r_state <= S_DONE;
            end else if (lbus_addr[11]) begin
              r_state <= S_DRP_REQ;
              r_den   <= 1'b1;
              r_dwe   <= r_wr;
              r_daddr <= lbus_addr[6:0];
              r_di    <= lbus_wdata;
            end else begin
              r_state <= S_LOCAL;
            end
          end
        end

        S_LOCAL: begin
          if (r_is_wr) begin
            if (r_addr == 11'h001) r_scratch <= r_wdata;
          end else begin
            case (r_addr)
              11'h000: r_rdata <= P_BLOCK_ID;
              11'h001: r_rdata <= r_scratch;
              11'h002: r_rdata <= r_err_cnt;
              default: r_rdata <= '0;
            endcase
          end
          r_wait_n <= 1'b1;
          r_state  <= S_DONE;
        end

        S_DRP_REQ: begin
          r_cnt   <= '0;
          r_state <= S_DRP_WAIT;
        end

        S_DRP_WAIT: begin
          if (drp_drdy) begin
            if (!r_is_wr) r_rdata <= drp_do;
            r_wait_n <= 1'b1;
            r_state  <= S_DONE;
          end else if (r_cnt == L_CNT_MAX) begin
            r_rdata <= L_DEAD;
            if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + P_BUS_DATA_WIDTH'(1);
            r_wait_n <= 1'b1;
            r_state  <= S_DONE;
          end else begin
            r_cnt <= r_cnt + L_CW'(1);
          end
        end

        S_DONE: begin
          r_wait_n <= 1'b1;
          if (!r_strobe) r_state <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign lbus_rdata  = r_rdata;
  assign lbus_wait_n = r_wait_n;
  assign drp_den     = r_den;
  assign drp_dwe     = r_dwe;
  assign drp_daddr   = r_daddr;
  assign drp_di      = r_di;

endmodule

// File: tb/tb_lbus_drp_slave.sv
// Self-checking bench for lbus_drp_slave: a CPU-side bus driver, a behavioural DRP
// device with programmable response delay, and a register-level model of the block.
module tb_lbus_drp_slave;

  localparam int AW = 12;
  localparam int DW = 16;
  localparam int T  = 64;

  logic          clk_cfg    = 1'b0;
  logic          rst_cfg    = 1'b1;
  logic [AW-1:0] lbus_addr  = '0;
  logic [DW-1:0] lbus_wdata = '0;
  logic [DW-1:0] lbus_rdata;
  logic          lbus_oe_n  = 1'b1;
  logic          lbus_we_n  = 1'b1;
  logic          lbus_wait_n;
  logic          drp_den;
  logic          drp_dwe;
  logic [6:0]    drp_daddr;
  logic [DW-1:0] drp_di;
  logic [DW-1:0] drp_do     = '0;
  logic          drp_drdy   = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state
  logic [DW-1:0] m_scratch = '0;
  logic [DW-1:0] m_err     = '0;
  logic [DW-1:0] m_drp [128];

  // DRP device state (owned by the responder process)
  logic [DW-1:0] dev_mem [128];
  int            drp_delay = 0;
  int            pend      = 0;
  int            den_cnt   = 0;
  logic [6:0]    den_addr  = '0;
  logic          den_we    = 1'b0;
  logic [DW-1:0] den_di    = '0;

  lbus_drp_slave #(
    .P_BUS_ADDR_WIDTH (AW),
    .P_BUS_DATA_WIDTH (DW),
    .P_DRP_TIMEOUT    (T),
    .P_BLOCK_ID       (16'h5844)
  ) dut (
    .clk_cfg     (clk_cfg),
    .rst_cfg     (rst_cfg),
    .lbus_addr   (lbus_addr),
    .lbus_wdata  (lbus_wdata),
    .lbus_rdata  (lbus_rdata),
    .lbus_oe_n   (lbus_oe_n),
    .lbus_we_n   (lbus_we_n),
    .lbus_wait_n (lbus_wait_n),
    .drp_den     (drp_den),
    .drp_dwe     (drp_dwe),
    .drp_daddr   (drp_daddr),
    .drp_di      (drp_di),
    .drp_do      (drp_do),
    .drp_drdy    (drp_drdy)
  );

  always #5 clk_cfg = ~clk_cfg;

  function automatic logic [DW-1:0] drp_init(int i);
    return 16'(16'h1234 + (i - 1) * 257);
  endfunction

  // DRP device: answers each den with one drdy pulse drp_delay cycles later (0 = never).
  initial begin
    for (int i = 0; i < 128; i++) dev_mem[i] = drp_init(i);
    forever begin
      @(negedge clk_cfg);
      drp_drdy = 1'b0;
      if (drp_den === 1'b1) begin
        den_cnt++;
        den_addr = drp_daddr;
        den_we   = drp_dwe;
        den_di   = drp_di;
        if (drp_dwe === 1'b1) dev_mem[drp_daddr] = drp_di;
        pend = drp_delay;
      end else if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          drp_drdy = 1'b1;
          drp_do   = den_we ? 16'($urandom) : dev_mem[den_addr];
        end
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // kind: 0 read, 1 write, 2 both strobes (illegal). lat = rising edges from strobe
  // low until wait_n seen high; low_at = rising edges until wait_n first seen low.
  task automatic bus_access(input logic [AW-1:0] addr, input int kind, input logic [DW-1:0] wd,
                            output logic [DW-1:0] rd, output int lat, output int low_at);
    bit seen_low;
    seen_low = 1'b0;
    lat      = -1;
    low_at   = -1;
    @(posedge clk_cfg);
    #1;
    lbus_addr  = addr;
    lbus_wdata = wd;
    if (kind != 1) lbus_oe_n = 1'b0;
    if (kind != 0) lbus_we_n = 1'b0;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      @(negedge clk_cfg);
      if (lbus_wait_n === 1'b0 && !seen_low) begin
        seen_low = 1'b1;
        low_at   = cyc - 1;
      end else if (lbus_wait_n === 1'b1 && seen_low) begin
        lat = cyc - 1;
        break;
      end
    end
    rd = lbus_rdata;
    n_checks++;
    if (lat < 0) begin
      n_fail++;
      $display("FAIL access_done addr=%h: wait_n not high again within 200 cycles (low_seen=%0d)", addr, seen_low);
    end
    lbus_oe_n = 1'b1;
    lbus_we_n = 1'b1;
    repeat (2) @(posedge clk_cfg);
  endtask

  function automatic logic [DW-1:0] exp_local(logic [10:0] a);
    case (a)
      11'h000: return 16'h5844;
      11'h001: return m_scratch;
      11'h002: return m_err;
      default: return '0;
    endcase
  endfunction

  task automatic test_reset;
    repeat (3) @(posedge clk_cfg);
    @(negedge clk_cfg);
    n_checks++; if (lbus_wait_n !== 1'b1) begin n_fail++; $display("FAIL reset_wait_n got=%b exp=1", lbus_wait_n); end
    n_checks++; if (lbus_rdata !== '0)    begin n_fail++; $display("FAIL reset_rdata got=%h exp=0000", lbus_rdata); end
    n_checks++; if (drp_den !== 1'b0)     begin n_fail++; $display("FAIL reset_den got=%b exp=0", drp_den); end
    n_checks++; if (drp_dwe !== 1'b0)     begin n_fail++; $display("FAIL reset_dwe got=%b exp=0", drp_dwe); end
    n_checks++; if (drp_daddr !== '0)     begin n_fail++; $display("FAIL reset_daddr got=%h exp=00", drp_daddr); end
    n_checks++; if (drp_di !== '0)        begin n_fail++; $display("FAIL reset_di got=%h exp=0000", drp_di); end
    @(posedge clk_cfg);
    #1 rst_cfg = 1'b0;
    repeat (2) @(posedge clk_cfg);
  endtask

  task automatic test_local;
    logic [DW-1:0] rd; int lat, low_at, d0;
    d0 = den_cnt;
    bus_access(12'h000, 0, '0, rd, lat, low_at);
    n_checks++; if (rd !== 16'h5844)            begin n_fail++; $display("FAIL id_rdata got=%h exp=5844", rd); end
    n_checks++; if (low_at < 1 || low_at > 2)   begin n_fail++; $display("FAIL id_wait_low got=%0d exp=1..2", low_at); end
    n_checks++; if (lat !== 3)                  begin n_fail++; $display("FAIL id_latency got=%0d exp=3", lat); end
    bus_access(12'h001, 1, 16'hA5A5, rd, lat, low_at);
    m_scratch = 16'hA5A5;
    n_checks++; if (rd !== 16'h0000)            begin n_fail++; $display("FAIL wr_scratch_rdata got=%h exp=0000", rd); end
    bus_access(12'h001, 0, '0, rd, lat, low_at);
    n_checks++; if (rd !== m_scratch)           begin n_fail++; $display("FAIL rd_scratch got=%h exp=%h", rd, m_scratch); end
    n_checks++; if (den_cnt !== d0)             begin n_fail++; $display("FAIL local_no_den got=%0d exp=%0d", den_cnt, d0); end
  endtask

  task automatic test_drp_read;
    logic [DW-1:0] rd; int lat, low_at, d0;
    drp_delay = 5;
    d0 = den_cnt;
    bus_access(12'h801, 0, '0, rd, lat, low_at);
    n_checks++; if (den_cnt !== d0 + 1)   begin n_fail++; $display("FAIL drd_den_count got=%0d exp=%0d", den_cnt - d0, 1); end
    n_checks++; if (den_we !== 1'b0)      begin n_fail++; $display("FAIL drd_dwe got=%b exp=0", den_we); end
    n_checks++; if (den_addr !== 7'h01)   begin n_fail++; $display("FAIL drd_daddr got=%h exp=01", den_addr); end
    n_checks++; if (rd !== 16'h1234)      begin n_fail++; $display("FAIL drd_rdata got=%h exp=1234", rd); end
    n_checks++; if (lat !== 3 + 5)        begin n_fail++; $display("FAIL drd_latency got=%0d exp=%0d", lat, 8); end
  endtask

  task automatic test_timeout;
    logic [DW-1:0] rd; int lat, low_at;
    drp_delay = 100;
    bus_access(12'h800, 0, '0, rd, lat, low_at);
    m_err = m_err + 1'b1;
    n_checks++; if (rd !== 16'hDEAD)      begin n_fail++; $display("FAIL to_rdata got=%h exp=DEAD", rd); end
    n_checks++; if (lat !== 3 + T)        begin n_fail++; $display("FAIL to_latency got=%0d exp=%0d", lat, 3 + T); end
    repeat (60) @(posedge clk_cfg);
    @(negedge clk_cfg);
    n_checks++; if (lbus_rdata !== 16'hDEAD) begin n_fail++; $display("FAIL late_drdy_rdata got=%h exp=DEAD", lbus_rdata); end
    n_checks++; if (lbus_wait_n !== 1'b1)    begin n_fail++; $display("FAIL late_drdy_wait_n got=%b exp=1", lbus_wait_n); end
    bus_access(12'h002, 0, '0, rd, lat, low_at);
    n_checks++; if (rd !== 16'h0001)      begin n_fail++; $display("FAIL err_cnt got=%h exp=0001", rd); end
  endtask

  task automatic test_drp_write;
    logic [DW-1:0] rd; int lat, low_at, d0;
    drp_delay = 2;
    d0 = den_cnt;
    bus_access(12'h840, 1, 16'h00FF, rd, lat, low_at);
    m_drp[7'h40] = 16'h00FF;
    n_checks++; if (den_cnt !== d0 + 1)   begin n_fail++; $display("FAIL dwr_den_count got=%0d exp=1", den_cnt - d0); end
    n_checks++; if (den_we !== 1'b1)      begin n_fail++; $display("FAIL dwr_dwe got=%b exp=1", den_we); end
    n_checks++; if (den_addr !== 7'h40)   begin n_fail++; $display("FAIL dwr_daddr got=%h exp=40", den_addr); end
    n_checks++; if (den_di !== 16'h00FF)  begin n_fail++; $display("FAIL dwr_di got=%h exp=00FF", den_di); end
    n_checks++; if (lat !== 3 + 2)        begin n_fail++; $display("FAIL dwr_latency got=%0d exp=5", lat); end
    n_checks++; if (rd !== 16'h0000)      begin n_fail++; $display("FAIL dwr_rdata got=%h exp=0000", rd); end
    drp_delay = 3;
    bus_access(12'h840, 0, '0, rd, lat, low_at);
    n_checks++; if (rd !== m_drp[7'h40])  begin n_fail++; $display("FAIL dwr_readback got=%h exp=%h", rd, m_drp[7'h40]); end
  endtask

  task automatic test_timeout_boundary;
    logic [DW-1:0] rd; int lat, low_at;
    drp_delay = T;
    bus_access(12'h80A, 0, '0, rd, lat, low_at);
    n_checks++; if (rd !== m_drp[7'h0A])  begin n_fail++; $display("FAIL tie_drdy_wins got=%h exp=%h", rd, m_drp[7'h0A]); end
    drp_delay = T + 1;
    bus_access(12'h80B, 0, '0, rd, lat, low_at);
    m_err = m_err + 1'b1;
    n_checks++; if (rd !== 16'hDEAD)      begin n_fail++; $display("FAIL just_late got=%h exp=DEAD", rd); end
    repeat (3) @(posedge clk_cfg);
    bus_access(12'h002, 0, '0, rd, lat, low_at);
    n_checks++; if (rd !== m_err)         begin n_fail++; $display("FAIL err_cnt_boundary got=%h exp=%h", rd, m_err); end
  endtask

  task automatic test_illegal;
    logic [DW-1:0] rd; int lat, low_at, d0;
    d0 = den_cnt;
    drp_delay = 2;
    bus_access(12'h001, 2, 16'h1111, rd, lat, low_at);
    n_checks++; if (rd !== 16'h0000)      begin n_fail++; $display("FAIL illegal_local_rdata got=%h exp=0000", rd); end
    bus_access(12'h805, 2, 16'h2222, rd, lat, low_at);
    n_checks++; if (rd !== 16'h0000)      begin n_fail++; $display("FAIL illegal_drp_rdata got=%h exp=0000", rd); end
    n_checks++; if (den_cnt !== d0)       begin n_fail++; $display("FAIL illegal_no_den got=%0d exp=0", den_cnt - d0); end
    bus_access(12'h001, 0, '0, rd, lat, low_at);
    n_checks++; if (rd !== m_scratch)     begin n_fail++; $display("FAIL illegal_scratch_kept got=%h exp=%h", rd, m_scratch); end
  endtask

  task automatic test_early_release;
    logic [DW-1:0] rd; int lat, low_at, d0;
    drp_delay = 8;
    d0 = den_cnt;
    @(posedge clk_cfg);
    #1;
    lbus_addr = 12'h803;
    lbus_oe_n = 1'b0;
    repeat (3) @(posedge clk_cfg);
    #1 lbus_oe_n = 1'b1;
    repeat (15) @(posedge clk_cfg);
    @(negedge clk_cfg);
    n_checks++; if (den_cnt !== d0 + 1)   begin n_fail++; $display("FAIL early_den_count got=%0d exp=1", den_cnt - d0); end
    n_checks++; if (lbus_wait_n !== 1'b1) begin n_fail++; $display("FAIL early_wait_n got=%b exp=1", lbus_wait_n); end
    bus_access(12'h000, 0, '0, rd, lat, low_at);
    n_checks++; if (rd !== 16'h5844 || lat !== 3) begin n_fail++; $display("FAIL early_next_access got=%h/%0d exp=5844/3", rd, lat); end
  endtask

  task automatic test_reset_mid;
    logic [DW-1:0] rd; int lat, low_at, d0;
    drp_delay = 30;
    d0 = den_cnt;
    @(posedge clk_cfg);
    #1;
    lbus_addr = 12'h805;
    lbus_oe_n = 1'b0;
    repeat (6) @(posedge clk_cfg);
    #1 rst_cfg = 1'b1;
    @(posedge clk_cfg);
    #1 rst_cfg = 1'b0;
    m_scratch = '0;
    m_err     = '0;
    @(negedge clk_cfg);
    n_checks++; if (lbus_wait_n !== 1'b1) begin n_fail++; $display("FAIL rstmid_wait_n got=%b exp=1", lbus_wait_n); end
    n_checks++; if (drp_den !== 1'b0)     begin n_fail++; $display("FAIL rstmid_den got=%b exp=0", drp_den); end
    n_checks++; if (lbus_rdata !== '0)    begin n_fail++; $display("FAIL rstmid_rdata got=%h exp=0000", lbus_rdata); end
    repeat (6) @(negedge clk_cfg);
    n_checks++; if (den_cnt !== d0 + 1)   begin n_fail++; $display("FAIL rstmid_den_reissued got=%0d exp=1", den_cnt - d0); end
    n_checks++; if (lbus_wait_n !== 1'b1) begin n_fail++; $display("FAIL rstmid_wait_held got=%b exp=1", lbus_wait_n); end
    lbus_oe_n = 1'b1;
    repeat (35) @(posedge clk_cfg);
    bus_access(12'h001, 0, '0, rd, lat, low_at);
    n_checks++; if (rd !== 16'h0000)      begin n_fail++; $display("FAIL rstmid_scratch got=%h exp=0000", rd); end
    bus_access(12'h002, 0, '0, rd, lat, low_at);
    n_checks++; if (rd !== 16'h0000)      begin n_fail++; $display("FAIL rstmid_err_cnt got=%h exp=0000", rd); end
  endtask

  task automatic test_random;
    logic [DW-1:0] rd, wd, exp_rd;
    logic [AW-1:0] a;
    int lat, low_at, d0, op, dly, exp_lat, exp_den;
    for (int n = 0; n < 40; n++) begin
      op = $urandom_range(0, 3);
      wd = 16'($urandom);
      d0 = den_cnt;
      if (op < 2) begin
        case ($urandom_range(0, 4))
          0: a = 12'h000;
          1: a = 12'h001;
          2: a = 12'h002;
          3: a = 12'h003;
          default: a = {1'b0, 11'($urandom)};
        endcase
        exp_rd  = (op == 0) ? exp_local(a[10:0]) : '0;
        if (op == 1 && a[10:0] == 11'h001) m_scratch = wd;
        exp_lat = 3;
        exp_den = 0;
      end else begin
        a   = {1'b1, 4'($urandom), 7'($urandom)};
        dly = $urandom_range(1, 12);
        drp_delay = dly;
        exp_rd  = (op == 2) ? m_drp[a[6:0]] : '0;
        if (op == 3) m_drp[a[6:0]] = wd;
        exp_lat = 3 + dly;
        exp_den = 1;
      end
      bus_access(a, op[0] ? 1 : 0, wd, rd, lat, low_at);
      n_checks++; if (rd !== exp_rd)             begin n_fail++; $display("FAIL rand%0d_rdata op=%0d addr=%h got=%h exp=%h", n, op, a, rd, exp_rd); end
      n_checks++; if (lat !== exp_lat)           begin n_fail++; $display("FAIL rand%0d_latency op=%0d got=%0d exp=%0d", n, op, lat, exp_lat); end
      n_checks++; if (den_cnt - d0 !== exp_den)  begin n_fail++; $display("FAIL rand%0d_den op=%0d got=%0d exp=%0d", n, op, den_cnt - d0, exp_den); end
    end
  endtask

  initial begin
    for (int i = 0; i < 128; i++) m_drp[i] = drp_init(i);
    test_reset();
    test_local();
    test_drp_read();
    test_timeout();
    test_drp_write();
    test_timeout_boundary();
    test_illegal();
    test_early_release();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
